// File: rtl/uart_tx_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit engine:
//   - tx_state_t : FSM state encoding (IDLE, SYNC, START, DATA, PARITY, STOP)
//   - tx_sel_t   : TX_OUT mux select (LOGIC_ONE, LOGIC_ZERO, DATA_BITS,
//                  PARITY_BIT)
//   - sel_for_state() : which mux source a given state drives onto the line
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    typedef enum logic [1:0] {
        LOGIC_ONE  = 2'd0,
        LOGIC_ZERO = 2'd1,
        DATA_BITS  = 2'd2,
        PARITY_BIT = 2'd3
    } tx_sel_t;

    // Line level source for each state. Anything unknown parks the line
    // at the idle (mark) level.
    function automatic tx_sel_t sel_for_state(input tx_state_t s);
        tx_sel_t sel;
        case (s)
            START:   sel = LOGIC_ZERO;
            DATA:    sel = DATA_BITS;
            PARITY:  sel = PARITY_BIT;
            default: sel = LOGIC_ONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_tx_engine_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_serializer
// DATA_WIDTH-bit right-shift register plus data-bit counter.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset (clears shift/count)
//   i_load       : capture i_data and clear the counter (priority over shift)
//   i_data       : parallel word
//   i_shift      : shift right by one and advance the counter
//   o_next_lsb   : value bit 0 of the register will hold after this edge,
//                  so the caller can register the line level in step with it
//   o_done       : counter is on the last data bit (DATA_WIDTH-1)
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    output logic                  o_next_lsb,
    output logic                  o_done
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        o_next_lsb = r_shift[0];
        if (i_load) begin
            o_next_lsb = i_data[0];
        end else if (i_shift) begin
            o_next_lsb = r_shift[1];
        end
    end

    assign o_done = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_engine
// One UART transmit channel: FSM, serializer, parity generator and line mux.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2
// stop bits. Each bit lasts one Baud_Tick period; TX_OUT is registered.
//
// Ports:
//   CLK, RST       : clock, synchronous active-high reset
//   Baud_Tick      : one-cycle strobe at each bit-period boundary
//   P_DATA         : word to send
//   Data_Valid     : P_DATA valid
//   Data_Ready     : engine can take a word
//   Parity_Enable  : insert parity bit
//   Parity_Type    : 0 even, 1 odd
//   Two_Stop       : 0 one stop bit, 1 two stop bits
//   TX_OUT         : serial line, idle high
//   Busy           : frame in progress (any state but IDLE)
//   Frame_Done     : one-cycle pulse after the last stop bit
//   o_dbg_state    : current FSM state
//
// Handshake: a word is taken on a rising edge where Data_Valid && Data_Ready.
// Data_Valid without Data_Ready is ignored; nothing is queued. Data, parity
// setting and stop-bit count are latched on that edge, so later changes on
// the config inputs only affect the next frame.
//
// Build option UART_TX_B2B_EN: Data_Ready is also raised during the final
// stop-bit tick; a word taken there goes straight to START, so consecutive
// frames have no idle gap. Without it, frames are separated by a SYNC period.
// -----------------------------------------------------------------------------
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    // Derived from DATA_WIDTH; leave at default.
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Baud_Tick,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Data_Ready,
    input  logic                  Parity_Enable,
    input  logic                  Parity_Type,
    input  logic                  Two_Stop,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  Frame_Done,
    output tx_state_t             o_dbg_state
);

    tx_state_t r_state;
    tx_state_t w_next_state;
    tx_sel_t   w_sel;

    logic r_tx_out;
    logic r_frame_done;
    logic r_par_en;
    logic r_par_bit;
    logic r_two_stop;
    logic r_stop_cnt;

    logic w_ready;
    logic w_xfer;
    logic w_shift;
    logic w_last_stop;
    logic w_frame_end;
    logic w_ser_next_lsb;
    logic w_ser_done;
    logic w_tx_next;

    // Stop counter has reached its final value (0 for one stop, 1 for two).
    assign w_last_stop = (r_stop_cnt == r_two_stop);

`ifdef UART_TX_B2B_EN
    assign w_ready = (r_state == IDLE) ||
                     ((r_state == STOP) && Baud_Tick && w_last_stop);
`else
    assign w_ready = (r_state == IDLE);
`endif

    assign w_xfer = Data_Valid && w_ready;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .i_load     (w_xfer),
        .i_data     (P_DATA),
        .i_shift    (w_shift),
        .o_next_lsb (w_ser_next_lsb),
        .o_done     (w_ser_done)
    );

    // Next state and per-edge strobes. A tick in the transfer cycle is not
    // used: IDLE only looks at the handshake, so SYNC waits a fresh tick.
    always_comb begin
        w_next_state = r_state;
        w_shift      = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) w_next_state = SYNC;
            end
            SYNC: begin
                if (Baud_Tick) w_next_state = START;
            end
            START: begin
                if (Baud_Tick) w_next_state = DATA;
            end
            DATA: begin
                if (Baud_Tick) begin
                    w_shift = 1'b1;
                    if (w_ser_done) begin
                        w_next_state = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (Baud_Tick) w_next_state = STOP;
            end
            STOP: begin
                if (Baud_Tick && w_last_stop) begin
                    w_frame_end  = 1'b1;
                    // w_xfer can only be set here in the back-to-back build.
                    w_next_state = w_xfer ? START : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Line level is chosen from the state being entered, so the registered
    // TX_OUT changes on the same edge as the state.
    always_comb begin
        w_sel = sel_for_state(w_next_state);
        case (w_sel)
            LOGIC_ZERO: w_tx_next = 1'b0;
            DATA_BITS:  w_tx_next = w_ser_next_lsb;
            PARITY_BIT: w_tx_next = r_par_bit;
            default:    w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_out     <= 1'b1;
            r_frame_done <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_two_stop   <= 1'b0;
            r_stop_cnt   <= 1'b0;
        end else begin
            r_tx_out     <= w_tx_next;
            r_frame_done <= w_frame_end;
            if (w_xfer) begin
                r_par_en   <= Parity_Enable;
                r_par_bit  <= (^P_DATA) ^ Parity_Type;
                r_two_stop <= Two_Stop;
            end
            if ((w_next_state == STOP) && (r_state != STOP)) begin
                r_stop_cnt <= 1'b0;
            end else if ((r_state == STOP) && Baud_Tick && !w_last_stop) begin
                r_stop_cnt <= 1'b1;
            end
        end
    end

    assign Data_Ready  = w_ready;
    assign TX_OUT      = r_tx_out;
    assign Busy        = (r_state != IDLE);
    assign Frame_Done  = r_frame_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Bench for uart_tx_engine: an 8-bit instance driven from a vector table and
// hand sequences, plus a 5-bit instance for the narrow-word frame. Baud_Tick
// is one cycle in every 16. Expected line bits are queued when a word is
// handed over and checked at mid-bit by a monitor.
// Build with +define+UART_TX_B2B_EN to exercise the back-to-back option.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;
    import uart_tx_pkg::*;

    // ---------------- clock / reset / tick ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;
    int   div = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div = (div == 15) ? 0 : div + 1;
        baud_tick = (div == 15);
    end

    // ---------------- DUTs ----------------
    logic [7:0] p_data8 = '0;
    logic       valid8 = 1'b0, pe8 = 1'b0, pt8 = 1'b0, ts8 = 1'b0;
    logic       ready8, tx8, busy8, fd8;
    tx_state_t  dbg8;

    logic [4:0] p_data5 = '0;
    logic       valid5 = 1'b0, pe5 = 1'b0, pt5 = 1'b0, ts5 = 1'b0;
    logic       ready5, tx5, busy5, fd5;
    tx_state_t  dbg5;

    uart_tx_engine #(.DATA_WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .Baud_Tick(baud_tick), .P_DATA(p_data8),
        .Data_Valid(valid8), .Data_Ready(ready8), .Parity_Enable(pe8),
        .Parity_Type(pt8), .Two_Stop(ts8), .TX_OUT(tx8), .Busy(busy8),
        .Frame_Done(fd8), .o_dbg_state(dbg8)
    );

    uart_tx_engine #(.DATA_WIDTH(5)) dut5 (
        .CLK(clk), .RST(rst), .Baud_Tick(baud_tick), .P_DATA(p_data5),
        .Data_Valid(valid5), .Data_Ready(ready5), .Parity_Enable(pe5),
        .Parity_Type(pt5), .Two_Stop(ts5), .TX_OUT(tx5), .Busy(busy5),
        .Frame_Done(fd5), .o_dbg_state(dbg5)
    );

`ifdef UART_TX_B2B_EN
    localparam int GAP_EXP = 0;
`else
    localparam int GAP_EXP = 1;
`endif

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;

    logic [1:0] exp_q[$];   // {tx, busy} per bit period, dut8
    int         len_q[$];   // bits per queued frame, dut8
    logic [1:0] exp5_q[$];  // {tx, busy} per bit period, dut5

    int   mid_cnt = 0, gap = 0, last_gap = -1, remaining = 0;
    int   cyc = 0, last_cycles = 0, fd_count = 0, glitches = 0;
    logic in_frame = 1'b0, measuring = 1'b0, prev_tx = 1'b1;
    logic tick_e = 1'b0, rst_e = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       ts;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Parity bit from a ones count: even parity makes the total even.
    function automatic logic model_parity(input int d, input int nbits, input logic odd);
        int ones = 0;
        for (int i = 0; i < nbits; i++) ones += (d >> i) & 1;
        return ((ones % 2) == 1) ^ odd;
    endfunction

    task automatic push_frame8(input logic [7:0] d, input logic pe, input logic par,
                               input logic ts);
        exp_q.push_back(2'b01);
        for (int i = 0; i < 8; i++) exp_q.push_back({d[i], 1'b1});
        if (pe) exp_q.push_back({par, 1'b1});
        exp_q.push_back(2'b11);
        if (ts) exp_q.push_back(2'b11);
        len_q.push_back(10 + int'(pe) + int'(ts));
    endtask

    // Mid-bit monitor for dut8; also measures start-to-Frame_Done time,
    // Frame_Done cycles, idle gap between frames and off-tick line changes.
    task automatic monitor8();
        logic [1:0] e;
        forever begin
            @(posedge clk);
            tick_e  = baud_tick;
            rst_e   = rst;
            mid_cnt = tick_e ? 0 : mid_cnt + 1;
            @(negedge clk);
            if (rst_e) begin
                exp_q.delete();
                len_q.delete();
                in_frame  = 1'b0;
                measuring = 1'b0;
                gap       = 0;
            end else begin
                if (tx8 !== prev_tx && !tick_e) glitches++;
                if (measuring) cyc++;
                if (fd8) begin
                    fd_count++;
                    if (measuring) begin
                        last_cycles = cyc;
                        measuring   = 1'b0;
                    end
                end
                if (!measuring && prev_tx && !tx8 && tick_e) begin
                    measuring = 1'b1;
                    cyc       = 0;
                end
                if (mid_cnt == 8) begin
                    if (!in_frame) begin
                        if (!tx8) begin
                            if (len_q.size() == 0) begin
                                check("unexpected_start", 1, 0);
                            end else begin
                                in_frame  = 1'b1;
                                remaining = len_q.pop_front();
                                last_gap  = gap;
                            end
                        end else begin
                            gap++;
                        end
                    end
                    if (in_frame) begin
                        if (exp_q.size() == 0) begin
                            check("scoreboard_underflow", 1, 0);
                            in_frame = 1'b0;
                        end else begin
                            e = exp_q.pop_front();
                            check("tx_busy_bit", int'({tx8, busy8}), int'(e));
                            remaining--;
                            if (remaining == 0) begin
                                in_frame = 1'b0;
                                gap      = 0;
                            end
                        end
                    end
                end
            end
            prev_tx = tx8;
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!baud_tick);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic pe, input logic pt,
                         input logic ts, input logic par, input logic keep);
        int n = 0;
        @(negedge clk);
        #1;
        p_data8 = d; pe8 = pe; pt8 = pt; ts8 = ts; valid8 = 1'b1;
        while (!ready8 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready8) begin
            check("handshake_timeout", 0, 1);
            valid8 = 1'b0;
            return;
        end
        push_frame8(d, pe, par, ts);
        @(posedge clk);
        if (!keep) begin
            @(negedge clk);
            valid8 = 1'b0;
        end
    endtask

    task automatic wait_done8();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || in_frame || busy8) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        logic [7:0] rd;
        logic [1:0] e5;

        fork
            monitor8();
        join_none

        // table: data, parity enable, parity type, two stop, parity bit, length
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 11};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 11};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 11};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 12};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 11};
        for (int i = 6; i < 8; i++) begin
            rd = 8'($urandom_range(0, 255));
            vecs[i].data    = rd;
            vecs[i].pe      = 1'b1;
            vecs[i].pt      = 1'($urandom_range(0, 1));
            vecs[i].ts      = 1'($urandom_range(0, 1));
            vecs[i].exp_par = model_parity(int'(rd), 8, vecs[i].pt);
            vecs[i].exp_len = 11 + int'(vecs[i].ts);
        end

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", int'(tx8), 1);
        check("rst_busy", int'(busy8), 0);
        check("rst_frame_done", int'(fd8), 0);
        check("rst_state", int'(dbg8), int'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ready", int'(ready8), 1);
        check("rst_tx5", int'(tx5), 1);
        check("rst_ready5", int'(ready5), 1);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 8; i++) begin
            fd0 = fd_count;
            send8(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ts, vecs[i].exp_par, 1'b0);
            check("busy_after_xfer", int'(busy8), 1);
            check("ready_after_xfer", int'(ready8), 0);
            wait_done8();
            check("frame_done_once", fd_count - fd0, 1);
            check("frame_cycles", last_cycles, vecs[i].exp_len * 16);
        end

        // ---------------- mid-frame Data_Valid ignored ----------------
        fd0 = fd_count;
        send8(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ticks(4);
        @(negedge clk);
        #1;
        p_data8 = 8'hFF; pe8 = 1'b1; pt8 = 1'b1; ts8 = 1'b0; valid8 = 1'b1;
        @(negedge clk);
        #1;
        valid8 = 1'b0;
        wait_done8();
        check("two_stop_done_once", fd_count - fd0, 1);
        check("two_stop_cycles", last_cycles, 11 * 16);
        repeat (40) @(negedge clk);
        #1;
        check("no_extra_frame_busy", int'(busy8), 0);
        check("no_extra_frame_done", fd_count - fd0, 1);

        // ---------------- reset during data bit 3 ----------------
        fd0 = fd_count;
        send8(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ticks(5);
        repeat (4) @(negedge clk);
        #1;
        check("pre_reset_bit3", int'(tx8), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_tx", int'(tx8), 1);
        check("abort_busy", int'(busy8), 0);
        check("abort_ready", int'(ready8), 1);
        check("abort_frame_done", int'(fd8), 0);
        check("abort_state", int'(dbg8), int'(IDLE));
        rst = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        check("abort_no_done", fd_count - fd0, 0);
        fd0 = fd_count;
        send8(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done8();
        check("after_abort_done", fd_count - fd0, 1);
        check("after_abort_cycles", last_cycles, 10 * 16);

        // ---------------- back-to-back request ----------------
        fd0 = fd_count;
        send8(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send8(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done8();
        check("b2b_done_count", fd_count - fd0, 2);
        check("b2b_gap", last_gap, GAP_EXP);
        check("b2b_cycles", last_cycles, 10 * 16);

        // ---------------- 5-bit instance, 0x1B odd parity ----------------
        exp5_q.push_back(2'b01);
        for (int i = 0; i < 5; i++) exp5_q.push_back({1'((5'h1B >> i) & 1), 1'b1});
        exp5_q.push_back({model_parity(27, 5, 1'b1), 1'b1});
        exp5_q.push_back(2'b11);
        @(negedge clk);
        #1;
        p_data5 = 5'h1B; pe5 = 1'b1; pt5 = 1'b1; ts5 = 1'b0; valid5 = 1'b1;
        check("w5_ready", int'(ready5), 1);
        @(posedge clk);
        @(negedge clk);
        valid5 = 1'b0;
        #1;
        check("w5_busy", int'(busy5), 1);
        wait_ticks(1);
        for (int k = 0; k < 8; k++) begin
            repeat (8) @(negedge clk);
            e5 = exp5_q.pop_front();
            check("w5_bit", int'({tx5, busy5}), int'(e5));
            wait_ticks(1);
        end
        @(negedge clk);
        #1;
        check("w5_frame_done", int'(fd5), 1);
        check("w5_idle_busy", int'(busy5), 0);
        @(negedge clk);
        #1;
        check("w5_done_pulse", int'(fd5), 0);

        // ---------------- wrap-up ----------------
        check("line_stable_within_bit", glitches, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
